// File: rtl/lti_ctrl_pkg.sv
// Shared control types for the LTI sample sequencer: FSM states, sticky flag
// bundle and the overrun-counter width.
package lti_ctrl_pkg;

  localparam int OVR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BUSY = 2'd2,
    OUT  = 2'd3
  } lti_state_e;

  typedef struct packed {
    logic underrun;
    logic overrun;
    logic timeout;
  } lti_flags_t;

  // Saturating increment for event counters
  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (v == '1) ? v : v + OVR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/lti_rate_tick.sv
// Sample-rate tick generator: counts 0..div while enabled and strobes tick at
// the terminal count; held at 0 while disabled.
module lti_rate_tick #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [DW-1:0] div,
  output logic          tick
);

  logic [DW-1:0] r_cnt;
  logic          w_wrap;

  // >= so that lowering div mid-period wraps at once instead of running to 2^DW
  assign w_wrap = (r_cnt >= div);
  assign tick   = enable & w_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n)                r_cnt <= '0;
    else if (!enable || w_wrap) r_cnt <= '0;
    else                       r_cnt <= r_cnt + DW'(1);
  end

endmodule

// File: rtl/lti_sequencer.sv
// Sample sequencer for a multi-cycle LTI datapath: paces input samples on a
// rate tick, launches one datapath step per tick and holds the result for a
// ready/valid consumer. Define LTI_SEQ_OVR_CNT_EN to build the overrun counter.
module lti_sequencer
  import lti_ctrl_pkg::*;
#(
  parameter int IW  = 16,
  parameter int OW  = 16,
  parameter int DW  = 16,
  parameter int TMO = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DW-1:0]        div,
  input  logic [IW-1:0]        s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [OW-1:0]        m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [IW-1:0]        dp_sig_in,
  output logic                 dp_ce_in,
  input  logic [OW-1:0]        dp_sig_out,
  input  logic                 dp_ce_out,
  input  logic                 clr_flags,
  output logic                 underrun,
  output logic                 overrun,
  output logic                 timeout,
  output logic [OVR_CNT_W-1:0] ovr_cnt
);

  localparam int WDW = $clog2(TMO + 2);

  lti_state_e     r_state, w_state_nxt;
  logic           w_tick, w_accept, w_drop, w_wd_exp;
  logic [WDW-1:0] r_wd;
  logic [IW-1:0]  r_sig_in;
  logic           r_ce_in;
  logic [OW-1:0]  r_m_data;
  logic           r_m_valid;
  lti_flags_t     r_flags;

  lti_rate_tick #(.DW(DW)) u_rate_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .div    (div),
    .tick   (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_wd_exp    = 1'b0;
    case (r_state)
      IDLE: if (enable) w_state_nxt = WAIT;
      WAIT: begin
        if (!enable) w_state_nxt = IDLE;
        else if (w_tick) begin
          w_accept    = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_drop = w_tick;
        if (dp_ce_out) w_state_nxt = OUT;
        else if (r_wd == WDW'(TMO)) begin
          w_wd_exp    = 1'b1;
          w_state_nxt = enable ? WAIT : IDLE;
        end
      end
      OUT: begin
        w_drop = w_tick;
        if (m_ready) w_state_nxt = enable ? WAIT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_wd     <= '0;
      r_sig_in <= '0;
      r_ce_in  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ce_in <= w_accept;
      // watchdog is 0 on the first BUSY cycle (the dp_ce_in cycle)
      r_wd    <= (r_state == BUSY) ? r_wd + WDW'(1) : '0;
      if (w_accept && s_valid) r_sig_in <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else if (r_state == BUSY && dp_ce_out) begin
      r_m_data  <= dp_sig_out;
      r_m_valid <= 1'b1;
    end else if (r_state == OUT && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  // Setting events take priority over clr_flags in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) r_flags <= '0;
    else begin
      if (w_accept && !s_valid) r_flags.underrun <= 1'b1;
      else if (clr_flags)       r_flags.underrun <= 1'b0;
      if (w_drop)               r_flags.overrun  <= 1'b1;
      else if (clr_flags)       r_flags.overrun  <= 1'b0;
      if (w_wd_exp)             r_flags.timeout  <= 1'b1;
      else if (clr_flags)       r_flags.timeout  <= 1'b0;
    end
  end

`ifdef LTI_SEQ_OVR_CNT_EN
  logic [OVR_CNT_W-1:0] r_ovr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)         r_ovr_cnt <= '0;
    else if (w_drop)    r_ovr_cnt <= clr_flags ? OVR_CNT_W'(1) : sat_inc(r_ovr_cnt);
    else if (clr_flags) r_ovr_cnt <= '0;
  end

  assign ovr_cnt = r_ovr_cnt;
`else
  assign ovr_cnt = '0;
`endif

  // Gated by rst_n so a sample is never reported consumed during reset
  assign s_ready   = rst_n & w_accept;
  assign dp_sig_in = r_sig_in;
  assign dp_ce_in  = r_ce_in;
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign underrun  = r_flags.underrun;
  assign overrun   = r_flags.overrun;
  assign timeout   = r_flags.timeout;

endmodule

// File: tb/tb_lti_sequencer.sv
// Directed bench for lti_sequencer with a 4-stage datapath model
// (dp_ce_out four cycles after dp_ce_in, dp_sig_out = ~sample).
module tb_lti_sequencer;
  import lti_ctrl_pkg::*;

`ifdef LTI_SEQ_OVR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable, s_valid, m_ready, clr_flags;
  logic [15:0] div, s_data;
  logic        s_ready, m_valid, dp_ce_in, dp_ce_out;
  logic [15:0] m_data, dp_sig_in, dp_sig_out, ovr_cnt;
  logic        underrun, overrun, timeout;

  logic        dp_dead = 1'b0;
  logic [3:0]  dp_pipe = 4'b0;
  logic [15:0] dp_hold = 16'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lti_sequencer #(.IW(16), .OW(16), .DW(16), .TMO(15)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .div(div),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .dp_sig_in(dp_sig_in), .dp_ce_in(dp_ce_in),
    .dp_sig_out(dp_sig_out), .dp_ce_out(dp_ce_out),
    .clr_flags(clr_flags), .underrun(underrun), .overrun(overrun),
    .timeout(timeout), .ovr_cnt(ovr_cnt)
  );

  // Datapath model; not reset, so a step in flight still returns after rst_n
  always @(posedge clk) begin
    dp_pipe <= {dp_pipe[2:0], (dp_ce_in === 1'b1) & ~dp_dead};
    if (dp_ce_in === 1'b1) dp_hold <= ~dp_sig_in;
  end
  assign dp_ce_out  = dp_pipe[3];
  assign dp_sig_out = dp_hold;

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; div = 16'd0; s_data = 16'h0; s_valid = 1'b0;
    m_ready = 1'b0; clr_flags = 1'b0;
    tk(3);
    chk("rst dp_sig_in", 32'(dp_sig_in), 32'h0);
    chk("rst m_data",    32'(m_data),    32'h0);
    chk("rst m_valid",   32'(m_valid),   32'h0);
    chk("rst s_ready",   32'(s_ready),   32'h0);
    chk("rst dp_ce_in",  32'(dp_ce_in),  32'h0);
    chk("rst flags",     {29'h0, underrun, overrun, timeout}, 32'h0);
    chk("rst ovr_cnt",   32'(ovr_cnt),   32'h0);
    chk("rst state",     32'(dut.r_state), 32'(IDLE));

    // nominal stream, div=9: P0 = this cycle, first tick at P9
    rst_n = 1'b1; enable = 1'b1; div = 16'd9; s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    tk(9);
    chk("nom tick s_ready", 32'(s_ready), 32'h1);
    chk("nom pre ce_in",    32'(dp_ce_in), 32'h0);
    tk(1);  // P10
    chk("nom ce_in",     32'(dp_ce_in),  32'h1);
    chk("nom sig_in",    32'(dp_sig_in), 32'h1234);
    tk(1);  // P11
    chk("nom ce_in pulse", 32'(dp_ce_in), 32'h0);
    chk("nom s_ready off", 32'(s_ready),  32'h0);
    tk(3);  // P14
    chk("nom m_valid early", 32'(m_valid), 32'h0);
    tk(1);  // P15
    chk("nom m_valid", 32'(m_valid), 32'h1);
    chk("nom m_data",  32'(m_data),  32'hEDCB);
    s_data = 16'h5678;
    tk(5);  // P20
    chk("nom 2nd ce_in",  32'(dp_ce_in),  32'h1);
    chk("nom 2nd sig_in", 32'(dp_sig_in), 32'h5678);
    chk("nom flags",      {29'h0, underrun, overrun, timeout}, 32'h0);

    // underrun on the third tick (P29)
    tk(8);  // P28
    s_valid = 1'b0;
    tk(1);  // P29
    chk("und s_ready", 32'(s_ready), 32'h1);
    tk(1);  // P30
    chk("und ce_in",    32'(dp_ce_in),  32'h1);
    chk("und sig_hold", 32'(dp_sig_in), 32'h5678);
    chk("und flag",     32'(underrun),  32'h1);
    s_valid = 1'b1; s_data = 16'h9ABC;
    tk(5);  // P35
    chk("und m_data", 32'(m_data), 32'hA987);
    clr_flags = 1'b1;
    tk(1);  // P36
    chk("und clr", 32'(underrun), 32'h0);
    clr_flags = 1'b0;

    // underrun and clr_flags together: the event wins
    tk(3);  // P39 (tick)
    s_valid = 1'b0; clr_flags = 1'b1;
    tk(1);  // P40
    chk("und beats clr", 32'(underrun), 32'h1);
    chk("und2 ce_in",    32'(dp_ce_in), 32'h1);
    s_valid = 1'b1; clr_flags = 1'b0;
    tk(1);  // P41: drop enable mid-step
    enable = 1'b0;
    tk(4);  // P45
    chk("dis step done", 32'(m_valid), 32'h1);
    chk("dis m_data",    32'(m_data),  32'hA987);
    tk(1);  // P46
    chk("dis m_valid off", 32'(m_valid), 32'h0);
    chk("dis state idle",  32'(dut.r_state), 32'(IDLE));

    // overrun, div=2: tick Q2 accepted, Q5 (BUSY) and Q8 (OUT) dropped
    div = 16'd2; enable = 1'b1; m_ready = 1'b0; s_data = 16'h0F0F;
    tk(6);  // Q6
    chk("ovr flag",   32'(overrun), 32'h1);
    chk("ovr cnt 1",  32'(ovr_cnt), CNT_EN ? 32'h1 : 32'h0);
    tk(2);  // Q8
    chk("ovr m_valid",   32'(m_valid), 32'h1);
    chk("ovr m_data q8", 32'(m_data),  32'hF0F0);
    tk(1);  // Q9
    chk("ovr m_data q9", 32'(m_data),  32'hF0F0);
    tk(1);  // Q10
    chk("ovr m_data q10", 32'(m_data), 32'hF0F0);
    chk("ovr m_valid q10", 32'(m_valid), 32'h1);
    m_ready = 1'b1;
    tk(1);  // Q11
    chk("ovr m_valid off", 32'(m_valid), 32'h0);
    chk("ovr cnt 2",       32'(ovr_cnt), CNT_EN ? 32'h2 : 32'h0);
    chk("ovr flag kept",   32'(overrun), 32'h1);
    chk("ovr s_ready",     32'(s_ready), 32'h1);
    tk(1);  // Q12
    chk("ovr next ce_in", 32'(dp_ce_in), 32'h1);
    enable = 1'b0;
    tk(6);  // Q18
    clr_flags = 1'b1;
    tk(1);  // Q19
    chk("clr overrun",  32'(overrun),  32'h0);
    chk("clr ovr_cnt",  32'(ovr_cnt),  32'h0);
    chk("clr underrun", 32'(underrun), 32'h0);
    clr_flags = 1'b0;

    // timeout: datapath never answers; ce_in at R10, timeout at R26
    dp_dead = 1'b1; div = 16'd9; enable = 1'b1; m_ready = 1'b1; s_data = 16'h1111;
    tk(10); // R10
    chk("tmo ce_in", 32'(dp_ce_in), 32'h1);
    tk(15); // R25
    chk("tmo not yet", 32'(timeout), 32'h0);
    tk(1);  // R26
    chk("tmo flag",    32'(timeout), 32'h1);
    chk("tmo state",   32'(dut.r_state), 32'(WAIT));
    chk("tmo m_valid", 32'(m_valid), 32'h0);
    chk("tmo overrun", 32'(overrun), 32'h1);
    dp_dead = 1'b0;
    tk(4);  // R30
    chk("tmo retry ce_in", 32'(dp_ce_in), 32'h1);

    // reset two cycles after dp_ce_in; its dp_ce_out lands at R34
    tk(2);  // R32
    rst_n = 1'b0;
    tk(1);  // R33
    rst_n = 1'b1;
    chk("mrst dp_sig_in", 32'(dp_sig_in), 32'h0);
    chk("mrst m_valid",   32'(m_valid),   32'h0);
    chk("mrst dp_ce_in",  32'(dp_ce_in),  32'h0);
    chk("mrst s_ready",   32'(s_ready),   32'h0);
    chk("mrst flags",     {29'h0, underrun, overrun, timeout}, 32'h0);
    chk("mrst ovr_cnt",   32'(ovr_cnt),   32'h0);
    chk("mrst state",     32'(dut.r_state), 32'(IDLE));
    m_ready = 1'b0; s_data = 16'hA5A5;
    tk(2);  // R35
    chk("late ce_out ignored", 32'(m_valid), 32'h0);
    chk("late m_data",         32'(m_data),  32'h0);

    // tick R42 -> m_valid R48; drop enable while in OUT
    tk(13); // R48
    chk("out m_valid", 32'(m_valid), 32'h1);
    chk("out m_data",  32'(m_data),  32'h5A5A);
    enable = 1'b0;
    tk(1);  // R49
    chk("out hold",  32'(m_valid), 32'h1);
    chk("out state", 32'(dut.r_state), 32'(OUT));
    m_ready = 1'b1;
    tk(1);  // R50
    chk("out done m_valid", 32'(m_valid), 32'h0);
    chk("out done state",   32'(dut.r_state), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lti_sequencer.md
LTI_SEQUENCER -- requirements
Module: lti_sequencer

Interface
REQ-001 SHALL have parameter IW, default 16: input sample width, equal to the datapath sig_in width.
REQ-002 SHALL have parameter OW, default 16: output sample width, equal to the datapath sig_out width.
REQ-003 SHALL have parameter DW, default 16: sample-rate divider width.
REQ-004 SHALL have parameter TMO, default 15: maximum cycles allowed from dp_ce_in to dp_ce_out.
REQ-005 SHALL have ports, one per line, name direction width meaning:
 clk  in  1  single clock; all logic rising-edge.
 rst_n  in  1  synchronous active-low reset.
 enable  in  1  run request.
 div  in  DW  sample period minus one, in clk cycles.
 s_data  in  IW  input sample.
 s_valid  in  1  input sample available.
 s_ready  out  1  input sample consumed this cycle.
 m_data  out  OW  output sample.
 m_valid  out  1  output sample held.
 m_ready  in  1  consumer accepts m_data.
 dp_sig_in  out  IW  sample to datapath.
 dp_ce_in  out  1  one-cycle datapath step strobe.
 dp_sig_out  in  OW  datapath output.
 dp_ce_out  in  1  datapath step complete.
 clr_flags  in  1  clears sticky flags.
 underrun  out  1  sticky: tick with no input sample.
 overrun  out  1  sticky: tick while a step is in flight.
 timeout  out  1  sticky: datapath failed to return.
 ovr_cnt  out  16  overrun event count.

Function
REQ-006 SHALL run a tick counter 0..div while enable=1, asserting tick for one cycle at count==div, then wrapping to 0; div=0 SHALL tick every cycle; the counter SHALL clear to 0 while enable=0.
REQ-007 SHALL implement states IDLE, WAIT, BUSY, OUT.
REQ-008 IDLE->WAIT when enable=1; WAIT->IDLE when enable=0.
REQ-009 In WAIT on tick: s_ready=1 combinationally in that cycle; if s_valid=1, s_data is registered into dp_sig_in; if s_valid=0, dp_sig_in holds its previous value and underrun sets; in both cases the next state is BUSY.
REQ-010 dp_ce_in SHALL pulse high for exactly one cycle, one cycle after the accepting tick; s_ready SHALL be 0 in every other cycle.
REQ-011 In BUSY, dp_ce_out=1 SHALL register dp_sig_out into m_data and move to OUT; m_valid is high from the next cycle.
REQ-012 In OUT, m_valid SHALL stay high and m_data SHALL stay stable until m_ready=1; then go to WAIT, or to IDLE if enable=0.
REQ-013 A tick in BUSY or OUT SHALL be dropped, set overrun, and increment ovr_cnt, which saturates at 0xFFFF.
REQ-014 A BUSY watchdog SHALL count cycles from entering BUSY; if dp_ce_out has not arrived by count TMO, timeout sets and the state returns to WAIT with m_valid=0.
REQ-015 enable=0 in BUSY or OUT SHALL NOT abort the step; the step completes, then the state goes to IDLE.
REQ-016 clr_flags=1 SHALL clear underrun, overrun, timeout and ovr_cnt; a flag-setting event in the same cycle SHALL win.
REQ-017 Nominal latency with the 4-stage datapath: tick at T, dp_ce_in at T+1, dp_ce_out at T+5, m_valid at T+6.

Reset
REQ-018 rst_n=0 at a clk edge SHALL force state IDLE, tick counter 0, and every output to 0 (dp_sig_in, m_data, m_valid, s_ready, dp_ce_in, flags, ovr_cnt), including mid-step; a later dp_ce_out SHALL then be ignored.

Configuration
REQ-019 With LTI_SEQ_OVR_CNT_EN defined, ovr_cnt SHALL behave per REQ-013; without it, ovr_cnt SHALL be constant 0, no counter logic SHALL be built, and the overrun flag SHALL be unaffected.

Structure
REQ-020 A shared package lti_ctrl_pkg SHALL hold the state enumeration (IDLE, WAIT, BUSY, OUT) and the ovr_cnt width constant (16).
REQ-021 The tick counter SHALL be a sub-module, lti_rate_tick (ports clk, rst_n, enable, div, tick), reusable by other samplers.

Verification
REQ-022 div=9, s_valid=1 constant, m_ready=1, datapath model with 4-cycle ce_out -> one dp_ce_in every 10 cycles; m_valid at tick+6; no flags set.
REQ-023 div=9, s_valid=0 at the third tick -> dp_ce_in still pulses; dp_sig_in repeats the prior sample; underrun=1; clr_flags clears it.
REQ-024 div=2, m_ready=0 for 8 cycles -> overrun=1, ovr_cnt=2; m_data stable throughout; with LTI_SEQ_OVR_CNT_EN undefined, ovr_cnt=0 and overrun=1.
REQ-025 Datapath model never returns dp_ce_out, TMO=15 -> timeout=1 at dp_ce_in+16; state back in WAIT; the next tick issues a new dp_ce_in.
REQ-026 rst_n=0 for one cycle, two cycles after dp_ce_in -> all outputs 0 and state IDLE; the late dp_ce_out produces no m_valid; enable=0 during OUT finishes the m_ready handshake, then IDLE.
